can_fd_crc_field_rx: RTL and testbench
======================================

CAN_FD_CRC_FIELD_RX -- requirements
Module: can_fd_crc_field_rx

Interface
REQ-001 Parameter FSB_PERIOD, default 5: a fixed stuff bit (FSB) occurs at every field position p where p % FSB_PERIOD == 0.
REQ-002 Parameter CRC_S_W, default 17: short CRC width, used when crc_long=0.
REQ-003 Parameter CRC_L_W, default 21: long CRC width, used when crc_long=1; CRC_L_W >= CRC_S_W.
REQ-004 Parameter SC_W, default 3: stuff-count Gray width; a single even-parity bit follows the Gray bits.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  bit strobe; data is valid only when enable=1.
REQ-008 start  in  1  asserted with enable on field position 0 (the first FSB).
REQ-009 data  in  1  received bit, dynamic destuffing already removed.
REQ-010 data_prev  in  1  last data-field bit; reference for the position-0 FSB check.
REQ-011 crc_long  in  1  CRC length select; sampled only when start=1 and enable=1.
REQ-012 dyn_stuff_cnt  in  SC_W  local dynamic stuff count mod 2^SC_W; sampled with start.
REQ-013 busy  out  1  field reception in progress.
REQ-014 done  out  1  one-cycle pulse: field complete, crc_o valid.
REQ-015 crc_o  out  CRC_L_W  received CRC, right-aligned; upper bits zero for short CRC.
REQ-016 stuff_cnt_o  out  SC_W  received Gray stuff count, raw.
REQ-017 fsb_error  out  1  sticky: an FSB did not equal the complement of the preceding bit.
REQ-018 sc_error  out  1  sticky: stuff-count Gray or parity mismatch.

Function
REQ-019 FSM states: IDLE, SC, CRC, DONE; position counter pos, 6 bits, increments by 1 on each accepted bit.
REQ-020 IDLE->SC on start&enable; pos=0 at that bit; crc_long and dyn_stuff_cnt latched; crc_o, stuff_cnt_o and error flags cleared.
REQ-021 start&enable in any non-IDLE state aborts the current field and restarts at pos=0, with no done pulse.
REQ-022 start without enable is ignored; enable=0 holds all state.
REQ-023 FSB check: at FSB positions, fsb_error sets if data == previous bit; previous bit is data_prev at pos 0, otherwise the last accepted bit.
REQ-024 FSB bits are never shifted into stuff_cnt_o or crc_o.
REQ-025 Non-FSB bits 1..SC_W shift MSB-first into stuff_cnt_o; the next non-FSB bit is the parity bit, compared against XOR of the received Gray bits; after it, SC->CRC.
REQ-026 sc_error sets if stuff_cnt_o != Gray(latched dyn_stuff_cnt), where Gray(n)=n^(n>>1), or if parity fails; it is evaluated once, on the parity bit.
REQ-027 In CRC, non-FSB bits shift MSB-first: crc_o <= {crc_o[CRC_L_W-2:0], data}; the short CRC uses the same shift with upper bits zero at start.
REQ-028 Last position L = (D-1) + ceil(D/(FSB_PERIOD-1)), where D = SC_W+1+CRC width; with defaults, L=26 (short) and L=31 (long).
REQ-029 On the bit at pos=L: CRC->DONE; done=1 on the next cycle only; DONE->IDLE unconditionally one cycle later.
REQ-030 Error flags are registered: visible the cycle after the offending bit, held until the next start or reset; errors do not abort reception.
REQ-031 busy=1 in SC, CRC and DONE; done=0 in all other states.

Reset
REQ-032 rst_n=0 immediately forces IDLE, pos=0, busy=0, done=0, crc_o=0, stuff_cnt_o=0, fsb_error=0, sc_error=0, regardless of clk.
REQ-033 Reset asserted mid-field discards the field; no done pulse follows reset release.

Verification
REQ-034 Short CRC: data_prev=0, dyn_stuff_cnt=3; bits: FSB 1, 0,1,0, parity 1, FSB 0, then CRC 17'h12345 with correct FSBs -> done at cycle after pos 26, crc_o=21'h012345, stuff_cnt_o=3'b010, no errors.
REQ-035 Long CRC: crc_long=1, CRC 21'h1ABCDE, correct stream -> done after pos 31, crc_o=21'h1ABCDE, fsb_error=0.
REQ-036 FSB at pos 10 equals previous bit -> fsb_error=1 from the next cycle; done still pulses at pos 26+1; flag cleared by the next start.
REQ-037 dyn_stuff_cnt=5 but received Gray 3'b110 (parity 0) -> sc_error=1 after the parity bit; a wrong parity bit alone with correct Gray also sets sc_error.
REQ-038 enable gaps of 3 cycles between bits -> identical crc_o and done timing relative to the last enabled bit.
REQ-039 rst_n low at pos 12, then a new start -> all outputs 0 during reset; the new field completes normally with no stale CRC bits.

Source files
------------

// File: rtl/can_fd_crc_field_rx.sv
// CAN FD CRC-field receiver: strips fixed stuff bits, captures the Gray stuff count
// with parity, then the short or long CRC, flagging FSB and stuff-count errors.
//
// state | meaning
// IDLE  | waiting for start&enable on the first FSB
// SC    | receiving Gray stuff-count bits and the parity bit
// CRC   | receiving CRC bits up to the last field position
// DONE  | one-cycle done pulse, crc_o valid
module can_fd_crc_field_rx #(
    parameter int FSB_PERIOD = 5,
    parameter int CRC_S_W    = 17,
    parameter int CRC_L_W    = 21,
    parameter int SC_W       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               start,
    input  logic               data,
    input  logic               data_prev,
    input  logic               crc_long,
    input  logic [SC_W-1:0]    dyn_stuff_cnt,
    output logic               busy,
    output logic               done,
    output logic [CRC_L_W-1:0] crc_o,
    output logic [SC_W-1:0]    stuff_cnt_o,
    output logic               fsb_error,
    output logic               sc_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SC   = 2'd1;
    localparam logic [1:0] S_CRC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int D_S  = SC_W + 1 + CRC_S_W;
    localparam int D_L  = SC_W + 1 + CRC_L_W;
    localparam int L_S  = (D_S - 1) + (D_S + FSB_PERIOD - 2) / (FSB_PERIOD - 1);
    localparam int L_L  = (D_L - 1) + (D_L + FSB_PERIOD - 2) / (FSB_PERIOD - 1);
    localparam int PH_W = (FSB_PERIOD > 1) ? $clog2(FSB_PERIOD) : 1;

    logic [1:0]         state_q, state_d;
    logic [5:0]         pos_q, pos_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [5:0]         nbit_q, nbit_d;
    logic               last_q, last_d;
    logic               crc_long_q, crc_long_d;
    logic [SC_W-1:0]    dyn_q, dyn_d;
    logic [CRC_L_W-1:0] crc_q, crc_d;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic               fsb_err_q, fsb_err_d;
    logic               sc_err_q, sc_err_d;

    logic               restart;
    logic [PH_W-1:0]    cur_ph;
    logic [PH_W-1:0]    next_ph;
    logic               is_fsb;
    logic               prev_bit;
    logic [SC_W-1:0]    gray_exp;
    logic [5:0]         last_pos;

    // FSB phase runs alongside pos so no modulo is needed on the position counter
    assign restart  = enable & start;
    assign cur_ph   = restart ? '0 : ph_q;
    assign next_ph  = (cur_ph == PH_W'(FSB_PERIOD - 1)) ? '0 : cur_ph + PH_W'(1);
    assign is_fsb   = (cur_ph == '0);
    assign prev_bit = restart ? data_prev : last_q;
    assign gray_exp = dyn_q ^ (dyn_q >> 1);
    assign last_pos = crc_long_q ? 6'(L_L) : 6'(L_S);

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        ph_d       = ph_q;
        nbit_d     = nbit_q;
        last_d     = last_q;
        crc_long_d = crc_long_q;
        dyn_d      = dyn_q;
        crc_d      = crc_q;
        sc_d       = sc_q;
        fsb_err_d  = fsb_err_q;
        sc_err_d   = sc_err_q;

        if (restart) begin
            state_d    = S_SC;
            pos_d      = 6'd1;
            ph_d       = next_ph;
            nbit_d     = '0;
            last_d     = data;
            crc_long_d = crc_long;
            dyn_d      = dyn_stuff_cnt;
            crc_d      = '0;
            sc_d       = '0;
            fsb_err_d  = (data == data_prev);
            sc_err_d   = 1'b0;
        end else begin
            case (state_q)
                S_SC, S_CRC: begin
                    if (enable) begin
                        last_d = data;
                        pos_d  = pos_q + 6'd1;
                        ph_d   = next_ph;
                        if (is_fsb) begin
                            if (data == prev_bit) fsb_err_d = 1'b1;
                        end else begin
                            nbit_d = nbit_q + 6'd1;
                            if (state_q == S_SC) begin
                                if (nbit_q < 6'(SC_W)) begin
                                    sc_d = {sc_q[SC_W-2:0], data};
                                end else begin
                                    // parity bit: Gray value and parity judged together here
                                    if ((sc_q != gray_exp) || (data != ^sc_q)) sc_err_d = 1'b1;
                                    state_d = S_CRC;
                                end
                            end else begin
                                crc_d = {crc_q[CRC_L_W-2:0], data};
                            end
                        end
                        if ((state_q == S_CRC) && (pos_q == last_pos)) state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            ph_q       <= '0;
            nbit_q     <= '0;
            last_q     <= 1'b0;
            crc_long_q <= 1'b0;
            dyn_q      <= '0;
            crc_q      <= '0;
            sc_q       <= '0;
            fsb_err_q  <= 1'b0;
            sc_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            ph_q       <= ph_d;
            nbit_q     <= nbit_d;
            last_q     <= last_d;
            crc_long_q <= crc_long_d;
            dyn_q      <= dyn_d;
            crc_q      <= crc_d;
            sc_q       <= sc_d;
            fsb_err_q  <= fsb_err_d;
            sc_err_q   <= sc_err_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign crc_o       = crc_q;
    assign stuff_cnt_o = sc_q;
    assign fsb_error   = fsb_err_q;
    assign sc_error    = sc_err_q;

endmodule

// File: tb/tb_can_fd_crc_field_rx.sv
// Directed bench for can_fd_crc_field_rx: table of complete fields plus hand-written
// reset, abort and ignored-start sequences.
module tb_can_fd_crc_field_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic        data;
    logic        data_prev;
    logic        crc_long;
    logic [2:0]  dyn_stuff_cnt;
    logic        busy;
    logic        done;
    logic [20:0] crc_o;
    logic [2:0]  stuff_cnt_o;
    logic        fsb_error;
    logic        sc_error;

    int checks = 0;
    int errors = 0;

    can_fd_crc_field_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .start         (start),
        .data          (data),
        .data_prev     (data_prev),
        .crc_long      (crc_long),
        .dyn_stuff_cnt (dyn_stuff_cnt),
        .busy          (busy),
        .done          (done),
        .crc_o         (crc_o),
        .stuff_cnt_o   (stuff_cnt_o),
        .fsb_error     (fsb_error),
        .sc_error      (sc_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        lng;
        logic [2:0]  dyn;
        logic [2:0]  gray;
        logic        par;
        logic [20:0] crcv;
        logic        dprev;
        int          errpos;
        int          gap;
        logic [20:0] exp_crc;
        logic [2:0]  exp_sc;
        logic        exp_fsb;
        logic        exp_scerr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Serialise a field: FSB = ~previous bit every 5th position (or a copy at errpos)
    task automatic build(input vec_t v, output logic [31:0] s, output int last);
        int   w;
        int   k;
        logic prev;
        logic b;
        w    = v.lng ? 21 : 17;
        last = v.lng ? 31 : 26;
        k    = 0;
        prev = v.dprev;
        s    = '0;
        for (int p = 0; p <= last; p++) begin
            if (p % 5 == 0) begin
                b = (p == v.errpos) ? prev : ~prev;
            end else begin
                if (k < 3)       b = v.gray[2-k];
                else if (k == 3) b = v.par;
                else             b = v.crcv[w-1-(k-4)];
                k++;
            end
            s[p] = b;
            prev = b;
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        @(negedge clk);
        enable = 1'b1;
        start  = st;
        data   = b;
        @(posedge clk);
        #1;
        enable = 1'b0;
        start  = 1'b0;
    endtask

    task automatic run_field(input vec_t v, input int stop_at, input logic final_chk);
        logic [31:0] s;
        int          last;
        int          bad_done;
        int          bad_fsb;
        logic        exp_f;
        build(v, s, last);
        crc_long      = v.lng;
        dyn_stuff_cnt = v.dyn;
        data_prev     = v.dprev;
        bad_done      = 0;
        bad_fsb       = 0;
        for (int p = 0; p <= last; p++) begin
            if (stop_at >= 0 && p == stop_at) return;
            send_bit(s[p], (p == 0));
            if (p < last) begin
                exp_f = (v.errpos >= 0) && (p >= v.errpos);
                if (done !== 1'b0 || busy !== 1'b1) bad_done++;
                if (fsb_error !== exp_f) bad_fsb++;
                for (int g = 0; g < v.gap; g++) begin
                    @(posedge clk);
                    #1;
                    if (done !== 1'b0 || busy !== 1'b1) bad_done++;
                    if (fsb_error !== exp_f) bad_fsb++;
                end
            end
        end
        if (!final_chk) return;
        chk({v.nm, " early_done"}, bad_done, 0);
        chk({v.nm, " fsb_timing"}, bad_fsb, 0);
        chk({v.nm, " done"}, done, 1);
        chk({v.nm, " busy"}, busy, 1);
        chk({v.nm, " crc_o"}, crc_o, v.exp_crc);
        chk({v.nm, " stuff_cnt_o"}, stuff_cnt_o, v.exp_sc);
        chk({v.nm, " fsb_error"}, fsb_error, v.exp_fsb);
        chk({v.nm, " sc_error"}, sc_error, v.exp_scerr);
        @(posedge clk);
        #1;
        chk({v.nm, " done_after"}, done, 0);
        chk({v.nm, " busy_after"}, busy, 0);
        chk({v.nm, " crc_hold"}, crc_o, v.exp_crc);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " crc_o"}, crc_o, 0);
        chk({nm, " stuff_cnt_o"}, stuff_cnt_o, 0);
        chk({nm, " fsb_error"}, fsb_error, 0);
        chk({nm, " sc_error"}, sc_error, 0);
    endtask

    initial begin
        //          name        lng   dyn   gray    par   crc           dprev err gap exp_crc       exp_sc  fsb   scerr
        vecs[0] = '{"short",    1'b0, 3'd3, 3'b010, 1'b1, 21'h012345,   1'b0, -1, 0, 21'h012345, 3'b010, 1'b0, 1'b0};
        vecs[1] = '{"long",     1'b1, 3'd0, 3'b000, 1'b0, 21'h1ABCDE,   1'b1, -1, 0, 21'h1ABCDE, 3'b000, 1'b0, 1'b0};
        vecs[2] = '{"fsb10",    1'b0, 3'd3, 3'b010, 1'b1, 21'h00F0F0,   1'b0, 10, 0, 21'h00F0F0, 3'b010, 1'b1, 1'b0};
        vecs[3] = '{"gray_bad", 1'b0, 3'd5, 3'b110, 1'b0, 21'h00ACE1,   1'b1, -1, 0, 21'h00ACE1, 3'b110, 1'b0, 1'b1};
        vecs[4] = '{"par_bad",  1'b0, 3'd5, 3'b111, 1'b0, 21'h01FFFF,   1'b0, -1, 0, 21'h01FFFF, 3'b111, 1'b0, 1'b1};
        vecs[5] = '{"gap3",     1'b0, 3'd3, 3'b010, 1'b1, 21'h012345,   1'b0, -1, 3, 21'h012345, 3'b010, 1'b0, 1'b0};
        vecs[6] = '{"long_gap", 1'b1, 3'd7, 3'b100, 1'b1, 21'h000001,   1'b1, -1, 1, 21'h000001, 3'b100, 1'b0, 1'b0};
        vecs[7] = '{"fsb0",     1'b1, 3'd2, 3'b011, 1'b0, 21'h155555,   1'b1,  0, 0, 21'h155555, 3'b011, 1'b1, 1'b0};

        rst_n         = 1'b0;
        enable        = 1'b0;
        start         = 1'b0;
        data          = 1'b0;
        data_prev     = 1'b0;
        crc_long      = 1'b0;
        dyn_stuff_cnt = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_field(vecs[i], -1, 1'b1);
            repeat (2) @(posedge clk);
        end

        // start without enable must not leave IDLE
        @(negedge clk);
        start = 1'b1;
        data  = 1'b1;
        @(posedge clk);
        #1;
        chk("start_no_en busy", busy, 0);
        start = 1'b0;

        // abort at pos 15 then restart: no done pulse, clean result
        run_field(vecs[1], 16, 1'b0);
        chk("abort busy", busy, 1);
        run_field(vecs[0], -1, 1'b1);
        repeat (2) @(posedge clk);

        // reset after pos 12 discards the field; next field has no stale bits
        run_field(vecs[6], 13, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset no_done", done, 0);
        run_field(vecs[3], -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
